// File: rtl/pito_pkg.sv
// Shared types for the pito SoC boot path: loader command bytes, loader FSM states
// and the default inter-byte timeout.
package pito_pkg;

    typedef enum logic [7:0] {
        CMD_LOAD_IMEM = 8'hA5,
        CMD_LOAD_DMEM = 8'h5A,
        CMD_RUN       = 8'hC3
    } boot_cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        CKSUM
    } boot_state_e;

    localparam int BOOT_TIMEOUT_DEFAULT = 1000000;

endpackage

// File: rtl/pito_boot_word_asm.sv
// Packs incoming data bytes little-endian into 32-bit words and keeps the running
// XOR of every byte accepted since the last clear.
module pito_boot_word_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o,
    output logic [7:0]  xor_o
);

    logic [23:0] lanes_q;
    logic [1:0]  lane_q;
    logic [7:0]  xor_q;

    // The word is complete combinationally on the 4th byte so the caller can register it.
    assign word_valid_o = byte_vld_i && (lane_q == 2'd3);
    assign word_o       = {byte_i, lanes_q};
    assign xor_o        = xor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lanes_q <= '0;
            lane_q  <= '0;
            xor_q   <= '0;
        end else if (clr_i) begin
            lanes_q <= '0;
            lane_q  <= '0;
            xor_q   <= '0;
        end else if (byte_vld_i) begin
            lanes_q <= {byte_i, lanes_q[23:8]};
            lane_q  <= lane_q + 2'd1;
            xor_q   <= xor_q ^ byte_i;
        end
    end

endmodule

// File: rtl/pito_boot_loader.sv
// UART-fed boot loader: parses CMD/CNT/ADR/data/CKSUM frames, writes words into the
// SoC imem or dmem ext port, and holds the core in reset until a RUN command.
module pito_boot_loader
    import pito_pkg::*;
#(
    parameter int IMEM_ADDR_W    = 10,
    parameter int DMEM_ADDR_W    = 10,
    parameter int TIMEOUT_CYCLES = BOOT_TIMEOUT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   imem_req,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic [3:0]             imem_be,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DMEM_ADDR_W-1:0] dmem_addr,
    output logic [31:0]            dmem_wdata,
    output logic [3:0]             dmem_be,
    output logic                   core_rst_n,
    output logic                   busy,
    output logic                   load_done,
    output logic                   err_cksum,
    output logic                   err_timeout
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    boot_state_e            state_q;
    logic                   tgt_dmem_q;
    logic [1:0]             hdr_cnt_q;
    logic [15:0]            cnt_q;
    logic [15:0]            addr_q;
    logic [TMO_W-1:0]       tmo_q;
    logic                   imem_req_q, dmem_req_q;
    logic [IMEM_ADDR_W-1:0] imem_addr_q;
    logic [DMEM_ADDR_W-1:0] dmem_addr_q;
    logic [31:0]            imem_wdata_q, dmem_wdata_q;
    logic                   core_rst_n_q, load_done_q, err_cksum_q, err_timeout_q;

    logic        word_valid;
    logic [31:0] word;
    logic [7:0]  run_xor;

    pito_boot_word_asm u_word_asm (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (state_q == IDLE),
        .byte_vld_i   (rx_valid && (state_q == DATA)),
        .byte_i       (rx_data),
        .word_valid_o (word_valid),
        .word_o       (word),
        .xor_o        (run_xor)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tgt_dmem_q    <= 1'b0;
            hdr_cnt_q     <= '0;
            cnt_q         <= '0;
            addr_q        <= '0;
            tmo_q         <= '0;
            imem_req_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            imem_addr_q   <= '0;
            dmem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            dmem_wdata_q  <= '0;
            core_rst_n_q  <= 1'b0;
            load_done_q   <= 1'b0;
            err_cksum_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            load_done_q <= 1'b0;
            if (state_q == IDLE) begin
                tmo_q <= '0;
                if (rx_valid) begin
                    if (rx_data == CMD_LOAD_IMEM || rx_data == CMD_LOAD_DMEM) begin
                        core_rst_n_q  <= 1'b0;
                        err_cksum_q   <= 1'b0;
                        err_timeout_q <= 1'b0;
                        tgt_dmem_q    <= (rx_data == CMD_LOAD_DMEM);
                        hdr_cnt_q     <= '0;
                        state_q       <= HDR;
                    end else if (rx_data == CMD_RUN) begin
                        core_rst_n_q  <= 1'b1;
                    end
                end
            end else if (rx_valid) begin
                // A byte in the expiry cycle is consumed and restarts the idle count.
                tmo_q <= '0;
                unique case (state_q)
                    HDR: begin
                        hdr_cnt_q <= hdr_cnt_q + 2'd1;
                        unique case (hdr_cnt_q)
                            2'd0: cnt_q[7:0]   <= rx_data;
                            2'd1: cnt_q[15:8]  <= rx_data;
                            2'd2: addr_q[7:0]  <= rx_data;
                            2'd3: begin
                                addr_q[15:8] <= rx_data;
                                state_q      <= (cnt_q == 16'd0) ? CKSUM : DATA;
                            end
                        endcase
                    end
                    DATA: begin
                        if (word_valid) begin
                            if (tgt_dmem_q) begin
                                dmem_req_q   <= 1'b1;
                                dmem_addr_q  <= addr_q[DMEM_ADDR_W-1:0];
                                dmem_wdata_q <= word;
                            end else begin
                                imem_req_q   <= 1'b1;
                                imem_addr_q  <= addr_q[IMEM_ADDR_W-1:0];
                                imem_wdata_q <= word;
                            end
                            addr_q <= addr_q + 16'd1;
                            cnt_q  <= cnt_q - 16'd1;
                            if (cnt_q == 16'd1) state_q <= CKSUM;
                        end
                    end
                    CKSUM: begin
                        if (rx_data != run_xor) err_cksum_q <= 1'b1;
                        load_done_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (tmo_q == TMO_LAST) begin
                state_q       <= IDLE;
                err_timeout_q <= 1'b1;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_we     = imem_req_q;
    assign imem_be     = {4{imem_req_q}};
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_req_q;
    assign dmem_be     = {4{dmem_req_q}};
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign core_rst_n  = core_rst_n_q;
    assign busy        = (state_q != IDLE);
    assign load_done   = load_done_q;
    assign err_cksum   = err_cksum_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_pito_boot_loader.sv
// Bench for pito_boot_loader: directed frame table, timeout/reset sequences and random
// frames, all scored against a byte-position frame model and an expected-write queue.
module tb_pito_boot_loader;

    localparam int IW  = 10;
    localparam int DW  = 10;
    localparam int TMO = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          imem_req, imem_we, dmem_req, dmem_we;
    logic [IW-1:0] imem_addr;
    logic [DW-1:0] dmem_addr;
    logic [31:0]   imem_wdata, dmem_wdata;
    logic [3:0]    imem_be, dmem_be;
    logic          core_rst_n, busy, load_done, err_cksum, err_timeout;

    pito_boot_loader #(.IMEM_ADDR_W(IW), .DMEM_ADDR_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .imem_req(imem_req), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_be(imem_be),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .core_rst_n(core_rst_n), .busy(busy), .load_done(load_done),
        .err_cksum(err_cksum), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    typedef struct {
        bit          dm;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t log_q[$];
    int  n_iw = 0, n_dw = 0, n_done = 0;

    // Frame model: position of each byte within the frame decides its meaning.
    bit          m_in = 0, m_tgt = 0, m_errc = 0, m_errt = 0, m_core = 0, m_done = 0;
    int          m_pos = 0, m_idle = 0;
    logic [31:0] m_hdr = 0, m_word = 0;
    logic [7:0]  m_xor = 0;

    function automatic void mdl_reset();
        m_in = 0; m_errc = 0; m_errt = 0; m_core = 0; m_done = 0; m_idle = 0;
    endfunction

    function automatic void mdl_byte(input logic [7:0] b);
        int cnt, k;
        m_idle = 0;
        if (!m_in) begin
            if (b == 8'hA5 || b == 8'h5A) begin
                m_in = 1; m_pos = 0; m_tgt = (b == 8'h5A);
                m_errc = 0; m_errt = 0; m_core = 0; m_xor = 0;
            end else if (b == 8'hC3) begin
                m_core = 1;
            end
        end else begin
            cnt = int'(m_hdr[15:0]);
            if (m_pos < 4) begin
                m_hdr[8*m_pos +: 8] = b;
            end else if (m_pos < 4 + 4*cnt) begin
                k = m_pos - 4;
                m_xor ^= b;
                m_word[8*(k%4) +: 8] = b;
                if (k % 4 == 3)
                    exp_q.push_back('{m_tgt, 16'((int'(m_hdr[31:16]) + k/4) % 1024), m_word});
            end else begin
                if (b != m_xor) m_errc = 1;
                m_done = 1;
                m_in = 0;
            end
            m_pos++;
        end
    endfunction

    function automatic void mdl_idle();
        if (m_in) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_in = 0; m_errt = 1; m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
    endfunction

    function automatic void sb_wr(input bit dm, input logic [15:0] a, input logic [31:0] d,
                                  input logic we, input logic [3:0] be);
        wr_t e;
        log_q.push_back('{dm, a, d});
        if (dm) n_dw++; else n_iw++;
        chk("wr_we_be", {27'd0, we, be}, 32'h1F);
        if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_write: port=%0d addr=%h data=%h required none", dm, a, d);
        end else begin
            e = exp_q.pop_front();
            chk("wr_port", {31'd0, dm}, {31'd0, e.dm});
            chk("wr_addr", {16'd0, a}, {16'd0, e.addr});
            chk("wr_data", d, e.data);
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req) sb_wr(1'b0, 16'(imem_addr), imem_wdata, imem_we, imem_be);
            if (dmem_req) sb_wr(1'b1, 16'(dmem_addr), dmem_wdata, dmem_we, dmem_be);
            chk("both_req", {31'd0, imem_req & dmem_req}, 32'd0);
            if (load_done) n_done++;
            chk("load_done", {31'd0, load_done}, {31'd0, m_done});
            chk("busy", {31'd0, busy}, {31'd0, m_in});
            chk("core_rst_n", {31'd0, core_rst_n}, {31'd0, m_core});
            chk("err_cksum", {31'd0, err_cksum}, {31'd0, m_errc});
            chk("err_timeout", {31'd0, err_timeout}, {31'd0, m_errt});
            m_done = 0;
        end
    end

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        mdl_byte(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            mdl_idle();
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_out"}, {imem_req, imem_we, imem_be, dmem_req, dmem_we, dmem_be,
                           core_rst_n, busy, load_done, err_cksum, err_timeout}, 32'd0);
        chk({nm, "_addr"}, {12'd0, imem_addr, dmem_addr}, 32'd0);
        chk({nm, "_wdata"}, imem_wdata | dmem_wdata, 32'd0);
    endtask

    task automatic rand_frame();
        logic [7:0] fr[$];
        logic [7:0] x, d;
        int cnt, r;
        logic [15:0] adr;
        cnt = $urandom_range(0, 4);
        adr = 16'($urandom);
        x = 8'h00;
        fr.push_back($urandom_range(0, 1) ? 8'hA5 : 8'h5A);
        fr.push_back(8'(cnt)); fr.push_back(8'h00);
        fr.push_back(adr[7:0]); fr.push_back(adr[15:8]);
        for (int i = 0; i < 4*cnt; i++) begin
            d = 8'($urandom); x ^= d; fr.push_back(d);
        end
        fr.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : x);
        foreach (fr[i]) begin
            r = $urandom_range(0, 99);
            if (r < 3) idle($urandom_range(TMO-2, TMO+1));
            else if (r < 25) idle($urandom_range(1, 3));
            send(fr[i]);
        end
        idle($urandom_range(0, 2));
        if ($urandom_range(0, 3) == 0) begin
            d = 8'($urandom);
            if (d != 8'hA5 && d != 8'h5A) send(d);
        end
    endtask

    typedef struct packed {
        logic [7:0] off;
        logic [7:0] n;
        logic       errc;
        logic       core;
        logic [3:0] iw;
        logic [3:0] dw;
        logic [3:0] done;
    } vec_t;

    logic [7:0] stim [45];
    vec_t       tv [5];

    initial begin
        int iw0, dw0, d0;
        stim = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'h90,
                 8'hC3,
                 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF,
                 8'h5A, 8'h02, 8'h00, 8'hFF, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
        tv[0] = '{off: 8'd0,  n: 8'd14, errc: 1'b0, core: 1'b0, iw: 4'd2, dw: 4'd0, done: 4'd1};
        tv[1] = '{off: 8'd14, n: 8'd1,  errc: 1'b0, core: 1'b1, iw: 4'd0, dw: 4'd0, done: 4'd0};
        tv[2] = '{off: 8'd15, n: 8'd6,  errc: 1'b0, core: 1'b0, iw: 4'd0, dw: 4'd0, done: 4'd1};
        tv[3] = '{off: 8'd21, n: 8'd10, errc: 1'b1, core: 1'b0, iw: 4'd1, dw: 4'd0, done: 4'd1};
        tv[4] = '{off: 8'd31, n: 8'd14, errc: 1'b0, core: 1'b0, iw: 4'd0, dw: 4'd2, done: 4'd1};

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Directed frames, bytes back to back.
        for (int v = 0; v < 5; v++) begin
            iw0 = n_iw; dw0 = n_dw; d0 = n_done;
            for (int i = 0; i < int'(tv[v].n); i++) send(stim[int'(tv[v].off) + i]);
            idle(3);
            chk($sformatf("tv%0d_err_cksum", v), {31'd0, err_cksum}, {31'd0, tv[v].errc});
            chk($sformatf("tv%0d_core_rst_n", v), {31'd0, core_rst_n}, {31'd0, tv[v].core});
            chk($sformatf("tv%0d_busy", v), {31'd0, busy}, 32'd0);
            chk($sformatf("tv%0d_imem_writes", v), 32'(n_iw - iw0), {28'd0, tv[v].iw});
            chk($sformatf("tv%0d_dmem_writes", v), 32'(n_dw - dw0), {28'd0, tv[v].dw});
            chk($sformatf("tv%0d_load_done", v), 32'(n_done - d0), {28'd0, tv[v].done});
        end
        chk("log_size", 32'(log_q.size()), 32'd5);
        if (log_q.size() == 5) begin
            chk("imem_w0", {log_q[0].addr, 16'd0} | {31'd0, log_q[0].dm}, 32'h0010_0000);
            chk("imem_w0_data", log_q[0].data, 32'h0000_0013);
            chk("imem_w1", {log_q[1].addr, 16'd0} | {31'd0, log_q[1].dm}, 32'h0011_0000);
            chk("imem_w1_data", log_q[1].data, 32'h0010_0093);
            chk("bad_ck_w", {log_q[2].addr, 16'd0} | {31'd0, log_q[2].dm}, 32'h0000_0000);
            chk("bad_ck_data", log_q[2].data, 32'hDEAD_BEEF);
            chk("wrap_w0", {log_q[3].addr, 16'd0} | {31'd0, log_q[3].dm}, 32'h03FF_0001);
            chk("wrap_w0_data", log_q[3].data, 32'h4433_2211);
            chk("wrap_w1", {log_q[4].addr, 16'd0} | {31'd0, log_q[4].dm}, 32'h0000_0001);
            chk("wrap_w1_data", log_q[4].data, 32'h8877_6655);
        end

        // Timeout: one cycle short stays alive, the full budget aborts.
        d0 = n_done; iw0 = n_iw;
        send(8'hA5); send(8'h01); send(8'h00);
        idle(TMO - 1);
        chk("tmo_alive_busy", {31'd0, busy}, 32'd1);
        chk("tmo_alive_err", {31'd0, err_timeout}, 32'd0);
        idle(1);
        chk("tmo_busy", {31'd0, busy}, 32'd0);
        chk("tmo_err", {31'd0, err_timeout}, 32'd1);
        chk("tmo_no_done", 32'(n_done - d0), 32'd0);
        chk("tmo_no_write", 32'(n_iw - iw0), 32'd0);
        send(8'hA5); send(8'h01); send(8'h00);
        idle(TMO - 1);
        send(8'h40);
        chk("tmo_edge_busy", {31'd0, busy}, 32'd1);
        chk("tmo_edge_err", {31'd0, err_timeout}, 32'd0);
        send(8'h00); send(8'h01); send(8'h02); send(8'h04); send(8'h08); send(8'h0F);
        idle(2);
        chk("tmo_edge_done", 32'(n_done - d0), 32'd1);
        chk("tmo_edge_write", 32'(n_iw - iw0), 32'd1);

        // Asynchronous reset in the middle of DATA.
        iw0 = n_iw;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h20); send(8'h00);
        send(8'h11); send(8'h22);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        mdl_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);
        chk("mid_rst_no_write", 32'(n_iw - iw0), 32'd0);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h20); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h44);
        idle(2);
        chk("post_rst_write", 32'(n_iw - iw0), 32'd1);
        chk("post_rst_cksum", {31'd0, err_cksum}, 32'd0);

        for (int f = 0; f < 60; f++) rand_frame();
        idle(TMO + 2);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
